// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table, blank pattern and scan phase type.
package seg7_pkg;

    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef enum logic {PH_BLANK, PH_DRIVE} seg7_phase_e;

    // Segment order is gfedcba, bit 0 = segment a.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_scan_tick_gen.sv
// Free-running modulo-DIV counter with a wrap strobe, shared by scanned I/O blocks.
module scan_tick_gen
    import seg7_pkg::*;
#(
    parameter  int DIV = 8192,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);

    logic [CW-1:0] r_cnt;

    assign o_wrap = (r_cnt == CW'(DIV - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (o_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with anti-ghost blanking per digit period.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 8192,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW:0] BLANK_END = (CW + 1)'(BLANK_CYCLES);
    localparam seg7_phase_e PH_START = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

    logic [CW-1:0]         w_cnt;
    logic                  w_cnt_wrap;
    logic                  w_frame_wrap;
    logic [IW-1:0]         r_idx;
    logic [VW-1:0]         r_shadow_val;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [VW-1:0]         r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic                  r_frame_start;
    seg7_phase_e           r_phase;
    seg7_phase_e           w_phase_nxt;
    logic [3:0]            w_nib;
    logic                  w_show;
    logic [7:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_sel_nxt;
    logic [7:0]            r_seg_p1;
    logic [NUM_DIGITS-1:0] r_sel_p1;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .i_clk   (clk_in),
        .i_rst_n (reset_n),
        .o_cnt   (w_cnt),
        .o_wrap  (w_cnt_wrap)
    );

    assign w_frame_wrap = w_cnt_wrap && (r_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
        end
    end

    // A load coinciding with the frame wrap bypasses the shadow so it is not lost for a frame.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_val  <= '0;
            r_shadow_dp   <= '0;
            r_disp_val    <= '0;
            r_disp_dp     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_frame_wrap) begin
                r_disp_val <= load ? value : r_shadow_val;
                r_disp_dp  <= load ? dp_in : r_shadow_dp;
            end
            r_frame_start <= w_frame_wrap;
        end
    end

    assign w_nib = r_disp_val[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    logic [IW-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_disp_val[4*i +: 4] != 4'h0) begin
                w_msd = IW'(i);
            end
        end
    end

    assign w_show = (r_idx <= w_msd);
`else
    assign w_show = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PH_START;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Phase tracks cnt: BLANK while cnt < BLANK_CYCLES, DRIVE for the rest of the period.
    always_comb begin
        w_phase_nxt = r_phase;
        w_seg_nxt   = '0;
        w_sel_nxt   = '0;
        if (w_cnt_wrap) begin
            w_phase_nxt = PH_START;
        end else if (({1'b0, w_cnt} + 1'b1) == BLANK_END) begin
            w_phase_nxt = PH_DRIVE;
        end
        if (r_phase == PH_DRIVE) begin
            w_sel_nxt = NUM_DIGITS'(1) << r_idx;
            w_seg_nxt = {r_disp_dp[r_idx], w_show ? seg7_glyph(w_nib) : SEG7_BLANK};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_p1 <= '0;
            r_sel_p1 <= '0;
        end else begin
            r_seg_p1 <= w_seg_nxt;
            r_sel_p1 <= w_sel_nxt;
        end
    end

    assign seg_out     = (SEG_ACTIVE_LOW != 0) ? ~r_seg_p1 : r_seg_p1;
    assign digit_sel   = (DIG_ACTIVE_LOW != 0) ? ~r_sel_p1 : r_sel_p1;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle digit period, 2 blank cycles.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        fs;

    logic        rst_b_n;
    logic [15:0] value_b;
    logic [3:0]  dp_b;
    logic        load_b;
    logic [7:0]  seg_b;
    logic [3:0]  sel_b;
    logic        fs_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk_in(clk), .reset_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .seg_out(seg), .digit_sel(sel), .frame_start(fs)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_lo (
        .clk_in(clk), .reset_n(rst_b_n), .value(value_b), .dp_in(dp_b), .load(load_b),
        .seg_out(seg_b), .digit_sel(sel_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered on the negedge where frame_start is high; checks every cycle of one frame
    // (exp = {d3,d2,d1,d0}) and returns on the next frame_start negedge. Up to two loads
    // may be issued at chosen cycles (k < 0 disables).
    task automatic check_frame(input string name, input logic [31:0] exp,
                               input int k1, input logic [15:0] v1, input logic [3:0] p1,
                               input int k2, input logic [15:0] v2, input logic [3:0] p2);
        for (int k = 1; k <= 32; k++) begin
            int         ph;
            int         d;
            logic [7:0] e_seg;
            logic [3:0] e_sel;
            @(negedge clk);
            ph = (k - 1) % 8;
            d  = (k - 1) / 8;
            if (ph < 2) begin
                e_seg = 8'h00;
                e_sel = 4'b0000;
            end else begin
                e_seg = exp[d*8 +: 8];
                e_sel = 4'b0001 << d;
            end
            chk($sformatf("%s k%0d seg", name, k), {24'h0, seg}, {24'h0, e_seg});
            chk($sformatf("%s k%0d sel", name, k), {28'h0, sel}, {28'h0, e_sel});
            chk($sformatf("%s k%0d fs", name, k), {31'h0, fs}, {31'h0, (k == 32)});
            if (k == k1 + 1 || k == k2 + 1) load = 1'b0;
            if (k == k1) begin
                load = 1'b1; value = v1; dp_in = p1;
            end
            if (k == k2) begin
                load = 1'b1; value = v2; dp_in = p2;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_0050;
        logic [7:0]  exp_d3_zero;
`ifdef SEG7_LZB_EN
        exp_0050    = 32'h00_00_6D_3F;
        exp_d3_zero = 8'h00;
`else
        exp_0050    = 32'h3F_3F_6D_3F;
        exp_d3_zero = 8'h3F;
`endif
        rst_n   = 1'b0;
        value   = 16'h0;
        dp_in   = 4'h0;
        load    = 1'b0;
        rst_b_n = 1'b0;
        value_b = 16'h0;
        dp_b    = 4'h0;
        load_b  = 1'b0;

        tick(3);
        chk("rst seg", {24'h0, seg}, 32'h00);
        chk("rst sel", {28'h0, sel}, 32'h0);
        chk("rst fs", {31'h0, fs}, 32'h0);
        chk("rst lo seg", {24'h0, seg_b}, 32'hFF);
        chk("rst lo sel", {28'h0, sel_b}, 32'hF);

        rst_n = 1'b1;
        tick(2);
        chk("post-rst blank seg", {24'h0, seg}, 32'h00);
        chk("post-rst blank sel", {28'h0, sel}, 32'h0);
        tick(1);
        chk("first drive seg", {24'h0, seg}, 32'h3F);
        chk("first drive sel", {28'h0, sel}, 32'h1);

        load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
        tick(1);
        load = 1'b0;
        tick(27);
        chk("fs before wrap", {31'h0, fs}, 32'h0);
        tick(1);
        chk("fs first wrap", {31'h0, fs}, 32'h1);
        chk("frame0 d3 seg", {24'h0, seg}, {24'h0, exp_d3_zero});
        chk("frame0 d3 sel", {28'h0, sel}, 32'h8);

        check_frame("f1234", 32'h06_5B_4F_66, 10, 16'hABCD, 4'b0000, -1, 16'h0, 4'h0);
        check_frame("fABCD", 32'h77_7C_39_5E, 14, 16'h12E4, 4'b0010, -1, 16'h0, 4'h0);
        check_frame("f12E4", 32'h06_5B_F9_66, 5, 16'hFFFF, 4'b1111, 20, 16'h0050, 4'b0000);
        check_frame("f0050", exp_0050, 31, 16'h89AB, 4'b1000, -1, 16'h0, 4'h0);
        check_frame("f89AB", 32'hFF_6F_77_7C, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        rst_b_n = 1'b1;
        load_b  = 1'b1; value_b = 16'h8888; dp_b = 4'b0000;
        tick(1);
        load_b = 1'b0;
        tick(34);
        chk("lo drive seg", {24'h0, seg_b}, 32'h80);
        chk("lo drive sel", {28'h0, sel_b}, 32'hE);
        #2;
        rst_b_n = 1'b0;
        #1;
        chk("lo async rst seg", {24'h0, seg_b}, 32'hFF);
        chk("lo async rst sel", {28'h0, sel_b}, 32'hF);
        chk("lo async rst fs", {31'h0, fs_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
